// File: rtl/bram_read_to_uart_if.sv
// BRAM read port between the UART sender (master) and the memory (slave).
interface bram_read_to_uart_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic [7:0]            bram_dout;

    modport master (
        output bram_addr,
        output bram_en,
        input  bram_dout
    );

    modport slave (
        input  bram_addr,
        input  bram_en,
        output bram_dout
    );
endinterface

// File: rtl/bram_read_to_uart.sv
// Reads a run of bytes from BRAM and sends each one as a UART 8N1 frame.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for write_to_uart_enable
// RD_REQ    | bram_en=1 for one cycle at the current address
// RD_WAIT   | BRAM latency cycle, bram_dout captured at its end
// START_BIT | TX=0 for CLKS_PER_BIT cycles
// DATA_BITS | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP_BIT  | TX=1 for CLKS_PER_BIT cycles, then next byte or DONE
// DONE      | one-cycle send_complete, back to IDLE
module bram_read_to_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 write_to_uart_enable,
    input  logic [31:0]          read_addr,
    input  logic [3:0]           bytes_to_send,
    bram_read_to_uart_if.master  bram,
    output logic                 TX,
    output logic                 busy,
    output logic                 send_complete
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, START_BIT, DATA_BITS, STOP_BIT, DONE
    } state_t;

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

    state_t                r_state, w_state_n;
    logic [15:0]           r_bit_cnt, w_bit_cnt_n;
    logic [2:0]            r_bit_idx, w_bit_idx_n;
    logic [7:0]            r_shift, w_shift_n;
    logic [3:0]            r_remain, w_remain_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic                  r_tx, w_tx_n;
    logic                  r_rst_ok;
    logic                  w_unused_addr_bits;

    assign w_unused_addr_bits = ^read_addr[31:ADDR_WIDTH];

    // State and datapath registers; reset clears everything, even mid-frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_remain  <= '0;
            r_addr    <= '0;
            r_tx      <= 1'b1;
            r_rst_ok  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_remain  <= w_remain_n;
            r_addr    <= w_addr_n;
            r_tx      <= w_tx_n;
            r_rst_ok  <= 1'b1;
        end
    end

    // Next-state and datapath logic; TX is derived from the next state so the
    // registered line lines up with the state it belongs to.
    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_remain_n  = r_remain;
        w_addr_n    = r_addr;
        w_tx_n      = 1'b1;

        case (r_state)
            IDLE: begin
                // r_rst_ok blocks a start on the first edge after reset release
                if (write_to_uart_enable && r_rst_ok) begin
                    w_addr_n   = read_addr[ADDR_WIDTH-1:0];
                    w_remain_n = bytes_to_send;
                    w_state_n  = (bytes_to_send == 4'd0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                w_state_n = RD_WAIT;
            end
            RD_WAIT: begin
                w_shift_n   = bram.bram_dout;
                w_bit_cnt_n = BIT_LOAD;
                w_state_n   = START_BIT;
            end
            START_BIT: begin
                if (r_bit_cnt == 16'd0) begin
                    w_bit_cnt_n = BIT_LOAD;
                    w_bit_idx_n = 3'd0;
                    w_state_n   = DATA_BITS;
                end else begin
                    w_bit_cnt_n = r_bit_cnt - 16'd1;
                end
            end
            DATA_BITS: begin
                if (r_bit_cnt == 16'd0) begin
                    w_bit_cnt_n = BIT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = STOP_BIT;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt - 16'd1;
                end
            end
            STOP_BIT: begin
                if (r_bit_cnt == 16'd0) begin
                    w_remain_n = r_remain - 4'd1;
                    w_addr_n   = r_addr + ADDR_WIDTH'(1);
                    w_state_n  = (r_remain == 4'd1) ? DONE : RD_REQ;
                end else begin
                    w_bit_cnt_n = r_bit_cnt - 16'd1;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_state_n == START_BIT) begin
            w_tx_n = 1'b0;
        end else if (w_state_n == DATA_BITS) begin
            w_tx_n = w_shift_n[w_bit_idx_n];
        end
    end

    assign TX             = r_tx;
    assign busy           = (r_state != IDLE) && (r_state != DONE);
    assign send_complete  = (r_state == DONE);
    assign bram.bram_en   = (r_state == RD_REQ);
    assign bram.bram_addr = r_addr;

endmodule

// File: tb/tb_bram_read_to_uart.sv
// Bench for bram_read_to_uart with CLKS_PER_BIT=4, ADDR_WIDTH=4.
module tb_bram_read_to_uart;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int FRAME = 10 * CPB + 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        write_to_uart_enable = 1'b0;
    logic [31:0] read_addr = '0;
    logic [3:0]  bytes_to_send = '0;
    logic        TX, busy, send_complete;

    bram_read_to_uart_if #(.ADDR_WIDTH(AW)) bif ();

    bram_read_to_uart #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .write_to_uart_enable (write_to_uart_enable),
        .read_addr            (read_addr),
        .bytes_to_send        (bytes_to_send),
        .bram                 (bif),
        .TX                   (TX),
        .busy                 (busy),
        .send_complete        (send_complete)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [16];

    // One-cycle-latency BRAM model
    always @(posedge CLK) begin
        if (bif.bram_en) bif.bram_dout <= mem[bif.bram_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [9:0] cap_bits;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Start a transfer at the current negedge and check every cycle up to
    // one IDLE cycle after send_complete. rs>0 re-pulses the start mid-run.
    task automatic run_xfer(input int a, input int n, input int rs, input int exp_done);
        int total;
        int sc_at;
        int p, f, q;
        int e_tx, e_en, e_busy, e_sc;
        logic [7:0] b;
        total = (n == 0) ? 1 : FRAME * n + 1;
        sc_at = -1;
        write_to_uart_enable = 1'b1;
        read_addr = 32'(a) | 32'hFFFF_FFF0 & 32'h0000_0100;
        bytes_to_send = 4'(n);
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge CLK);
            if (c == 1) write_to_uart_enable = 1'b0;
            if (rs != 0 && c == rs) begin
                write_to_uart_enable = 1'b1;
                read_addr = 32'd9;
                bytes_to_send = 4'd7;
            end
            if (rs != 0 && c == rs + 1) write_to_uart_enable = 1'b0;
            p = c - 1;
            e_en = 0;
            if (p == FRAME * n) begin
                e_tx = 1; e_busy = 0; e_sc = 1;
            end else if (p > FRAME * n) begin
                e_tx = 1; e_busy = 0; e_sc = 0;
            end else begin
                f = p / FRAME;
                q = p % FRAME;
                b = mem[(a + f) % 16];
                e_busy = 1; e_sc = 0;
                e_en = (q == 0) ? 1 : 0;
                if (q < 2)       e_tx = 1;
                else if (q < 6)  e_tx = 0;
                else if (q < 38) e_tx = int'(b[(q - 6) / CPB]);
                else             e_tx = 1;
                if (f == 0 && q >= 4 && (q % CPB) == 0 && q <= 40)
                    cap_bits[(q - 4) / CPB] = TX;
                if (e_en == 1)
                    chk($sformatf("bram_addr a=%0d n=%0d c=%0d", a, n, c),
                        int'(bif.bram_addr), (a + f) % 16);
            end
            chk($sformatf("tx a=%0d n=%0d c=%0d", a, n, c), int'(TX), e_tx);
            chk($sformatf("bram_en a=%0d n=%0d c=%0d", a, n, c), int'(bif.bram_en), e_en);
            chk($sformatf("busy a=%0d n=%0d c=%0d", a, n, c), int'(busy), e_busy);
            chk($sformatf("send_complete a=%0d n=%0d c=%0d", a, n, c), int'(send_complete), e_sc);
            if (send_complete) sc_at = c;
        end
        chk($sformatf("done_cycle a=%0d n=%0d", a, n), sc_at, exp_done);
    endtask

    typedef struct {
        int addr;
        int n;
        int restart_at;
        int exp_done;
    } vec_t;

    vec_t tv [5];

    initial begin
        tv[0] = '{addr: 1,  n: 1,  restart_at: 0,  exp_done: 43};
        tv[1] = '{addr: 14, n: 3,  restart_at: 0,  exp_done: 127};
        tv[2] = '{addr: 0,  n: 0,  restart_at: 0,  exp_done: 1};
        tv[3] = '{addr: 3,  n: 2,  restart_at: 50, exp_done: 85};
        tv[4] = '{addr: 0,  n: 15, restart_at: 0,  exp_done: 631};

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i * 7);
        mem[1]  = 8'hA5;
        mem[14] = 8'h11;
        mem[15] = 8'h22;
        mem[0]  = 8'h33;

        repeat (5) @(negedge CLK);
        chk("reset tx", int'(TX), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset send_complete", int'(send_complete), 0);
        chk("reset bram_en", int'(bif.bram_en), 0);
        chk("reset bram_addr", int'(bif.bram_addr), 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            run_xfer(tv[i].addr, tv[i].n, tv[i].restart_at, tv[i].exp_done);
            if (i == 0) chk("frame bits 0xA5", int'(cap_bits), int'(10'b1101001010));
        end

        // Asynchronous reset in the middle of DATA_BITS
        write_to_uart_enable = 1'b1;
        read_addr = 32'd1;
        bytes_to_send = 4'd1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 1) write_to_uart_enable = 1'b0;
        end
        chk("mid data tx low", int'(TX), 0);
        chk("mid data busy", int'(busy), 1);
        RST_N = 1'b0;
        #1;
        chk("async reset tx", int'(TX), 1);
        chk("async reset busy", int'(busy), 0);
        chk("async reset send_complete", int'(send_complete), 0);
        chk("async reset bram_en", int'(bif.bram_en), 0);
        chk("async reset bram_addr", int'(bif.bram_addr), 0);
        repeat (3) @(negedge CLK);

        // Start held only across the first edge after release must be ignored
        RST_N = 1'b1;
        write_to_uart_enable = 1'b1;
        @(negedge CLK);
        write_to_uart_enable = 1'b0;
        chk("no start on first edge busy", int'(busy), 0);
        @(negedge CLK);
        chk("no start on first edge busy2", int'(busy), 0);
        chk("no start on first edge bram_en", int'(bif.bram_en), 0);
        @(negedge CLK);

        run_xfer(1, 1, 0, 43);
        chk("frame bits after reset", int'(cap_bits), int'(10'b1101001010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
